// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding,
// default instruction-memory address width and the per-instruction address step.
package inst_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_HI,
      GET_LO,
      WRITE,
      FINISH
   } state_e;

   // Halfword-address width of the instruction memory.
   localparam int unsigned ADDR_BITS_DEFAULT = 20;

   // One 32-bit instruction occupies two halfword addresses.
   localparam int unsigned ADDR_STEP = 2;

   // Width of the instruction counter (matches the Word_Count port).
   localparam int unsigned COUNT_BITS = 20;

endpackage : inst_loader_pkg

// File: rtl/inst_loader.sv
// Instruction loader: assembles pairs of incoming halfwords (upper first)
// into 32-bit instructions and writes them to consecutive even halfword
// addresses of the instruction memory, wrapping at 2^ADDR_BITS.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Start,
   input  logic [31:0] Start_Address,
   input  logic [19:0] Word_Count,
   input  logic [15:0] In_Data,
   input  logic        In_Valid,
   output logic        In_Ready,
   output logic [31:0] OP_Code,
   output logic [31:0] Write_Address,
   output logic        Write_Enable,
   output logic        Busy,
   output logic        Done
);

   localparam logic [ADDR_BITS-1:0]  STEP      = ADDR_BITS'(ADDR_STEP);
   localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1);

   state_e                 state_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [ADDR_BITS-1:0]   addr_d;
   logic [COUNT_BITS-1:0]  count_q;
   logic [COUNT_BITS-1:0]  count_d;
   logic [31:0]            op_q;
   logic                   ready_q;
   logic                   we_q;
   logic                   busy_q;
   logic                   done_q;

   logic                   hs;
   logic [ADDR_BITS-1:0]   start_addr_even;

   // Address bits above the memory width and the halfword-select bit are
   // deliberately ignored when latching the start address.
   logic                   unused_addr_bits;
   assign unused_addr_bits = ^{Start_Address[31:ADDR_BITS], Start_Address[0]};

   assign hs              = In_Valid & ready_q;
   assign start_addr_even = {Start_Address[ADDR_BITS-1:1], 1'b0};

   // Address/count values taken when an instruction write completes.
   always_comb begin
      addr_d  = addr_q + STEP;
      count_d = count_q - COUNT_ONE;
   end

   // Load sequencer: state, datapath registers and registered handshake/status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         count_q <= '0;
         op_q    <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  if (Word_Count != '0) begin
                     addr_q  <= start_addr_even;
                     count_q <= Word_Count;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= GET_HI;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= FINISH;
                  end
               end
            end

            GET_HI: begin
               if (hs) begin
                  op_q[31:16] <= In_Data;
                  state_q     <= GET_LO;
               end
            end

            GET_LO: begin
               if (hs) begin
                  op_q[15:0] <= In_Data;
                  ready_q    <= 1'b0;
                  we_q       <= 1'b1;
                  state_q    <= WRITE;
               end
            end

            WRITE: begin
               we_q    <= 1'b0;
               addr_q  <= addr_d;
               count_q <= count_d;
               if (count_d != '0) begin
                  ready_q <= 1'b1;
                  state_q <= GET_HI;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FINISH;
               end
            end

            FINISH: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               ready_q <= 1'b0;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign In_Ready      = ready_q;
   assign OP_Code       = op_q;
   assign Write_Address = 32'(addr_q);
   assign Write_Enable  = we_q;
   assign Busy          = busy_q;
   assign Done          = done_q;

endmodule : inst_loader

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        Start;
   logic [31:0] Start_Address;
   logic [19:0] Word_Count;
   logic [15:0] In_Data;
   logic        In_Valid;
   logic        In_Ready;
   logic [31:0] OP_Code;
   logic [31:0] Write_Address;
   logic        Write_Enable;
   logic        Busy;
   logic        Done;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Write/Done observer state, sampled on the falling edge.
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int unsigned done_cnt;
   logic        busy_seen;
   logic        hi_bad;

   logic [15:0] stream [8];

   inst_loader #(.ADDR_BITS(20)) dut (
      .clk           (clk),
      .rst           (rst),
      .Start         (Start),
      .Start_Address (Start_Address),
      .Word_Count    (Word_Count),
      .In_Data       (In_Data),
      .In_Valid      (In_Valid),
      .In_Ready      (In_Ready),
      .OP_Code       (OP_Code),
      .Write_Address (Write_Address),
      .Write_Enable  (Write_Enable),
      .Busy          (Busy),
      .Done          (Done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (Write_Enable) begin
         wr_addr_q.push_back(Write_Address);
         wr_data_q.push_back(OP_Code);
      end
      if (Done) done_cnt++;
      if (Busy) busy_seen = 1'b1;
      if (Write_Address[31:20] != 12'h000) hi_bad = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] wr_addr(input int unsigned i);
      if (i < wr_addr_q.size()) return wr_addr_q[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] wr_data(input int unsigned i);
      if (i < wr_data_q.size()) return wr_data_q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_cnt  = 0;
      busy_seen = 1'b0;
      hi_bad    = 1'b0;
   endtask

   // Runs one load with In_Valid held high, feeding stream[] in order on each
   // handshake. Optionally pulses Start (addr 0x200) after edges ra/rb.
   // done_cyc = edge index after which Done was seen (0 = never).
   task automatic run_load(input logic [31:0] addr, input logic [19:0] cnt,
                           input int unsigned ra, input int unsigned rb,
                           output int unsigned done_cyc);
      int unsigned idx;
      logic        hs;
      idx           = 0;
      done_cyc      = 0;
      Start         = 1'b1;
      Start_Address = addr;
      Word_Count    = cnt;
      In_Valid      = 1'b1;
      In_Data       = stream[0];
      for (int unsigned cyc = 1; cyc <= 60; cyc++) begin
         hs = In_Valid && In_Ready;
         @(posedge clk); #1;
         if (hs) idx++;
         Start         = (cyc == ra) || (cyc == rb);
         Start_Address = Start ? 32'h0000_0200 : addr;
         Word_Count    = Start ? 20'd5 : cnt;
         In_Data       = stream[idx % 8];
         if (Done) begin
            done_cyc = cyc;
            break;
         end
      end
      Start    = 1'b0;
      In_Valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; Start = 1'b0; Start_Address = '0; Word_Count = '0;
      In_Data = '0; In_Valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (OP_Code !== 32'h0) begin failures++; $display("FAIL reset_opcode got=%h exp=%h", OP_Code, 32'h0); end
      checks++; if (Write_Address !== 32'h0) begin failures++; $display("FAIL reset_waddr got=%h exp=%h", Write_Address, 32'h0); end
      checks++; if ({Write_Enable, In_Ready, Busy, Done} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {Write_Enable, In_Ready, Busy, Done}); end
      // Start presented together with reset release is taken on the next edge.
      rst = 1'b0; Start = 1'b1; Start_Address = 32'h10; Word_Count = 20'd1;
      @(posedge clk); #1;
      Start = 1'b0;
      checks++; if ({Busy, In_Ready} !== 2'b11) begin failures++; $display("FAIL first_start got=%b exp=11", {Busy, In_Ready}); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int unsigned dc;
      clear_mon();
      stream[0] = 16'h1234; stream[1] = 16'h5678; stream[2] = 16'h9ABC; stream[3] = 16'hDEF0;
      run_load(32'h100, 20'd2, 0, 0, dc);
      checks++; if (dc !== 7) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=7", dc); end
      checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("FAIL basic_nwrites got=%0d exp=2", wr_addr_q.size()); end
      checks++; if (wr_addr(0) !== 32'h100 || wr_data(0) !== 32'h12345678) begin failures++; $display("FAIL basic_wr0 got=%h@%h exp=12345678@00000100", wr_data(0), wr_addr(0)); end
      checks++; if (wr_addr(1) !== 32'h102 || wr_data(1) !== 32'h9ABCDEF0) begin failures++; $display("FAIL basic_wr1 got=%h@%h exp=9abcdef0@00000102", wr_data(1), wr_addr(1)); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_wrap();
      int unsigned dc;
      clear_mon();
      stream[0] = 16'h0001; stream[1] = 16'h0002; stream[2] = 16'h0003; stream[3] = 16'h0004;
      run_load(32'h000F_FFFE, 20'd2, 0, 0, dc);
      checks++; if (dc !== 7) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=7", dc); end
      checks++; if (wr_addr(0) !== 32'h000F_FFFE || wr_data(0) !== 32'h0001_0002) begin failures++; $display("FAIL wrap_wr0 got=%h@%h exp=00010002@000ffffe", wr_data(0), wr_addr(0)); end
      checks++; if (wr_addr(1) !== 32'h0 || wr_data(1) !== 32'h0003_0004) begin failures++; $display("FAIL wrap_wr1 got=%h@%h exp=00030004@00000000", wr_data(1), wr_addr(1)); end
      checks++; if (hi_bad !== 1'b0) begin failures++; $display("FAIL wrap_upper_bits got=%b exp=0", hi_bad); end
   endtask

   task automatic test_zero_count();
      clear_mon();
      Start = 1'b1; Start_Address = 32'h40; Word_Count = 20'd0;
      @(posedge clk); #1;
      Start = 1'b0;
      checks++; if (Done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", Done); end
      @(posedge clk); #1;
      checks++; if (Done !== 1'b0) begin failures++; $display("FAIL zero_done_end got=%b exp=0", Done); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wr_addr_q.size() !== 0 || busy_seen !== 1'b0) begin failures++; $display("FAIL zero_no_activity got writes=%0d busy=%b exp writes=0 busy=0", wr_addr_q.size(), busy_seen); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_valid_stall();
      clear_mon();
      Start = 1'b1; Start_Address = 32'h40; Word_Count = 20'd1; In_Valid = 1'b0;
      @(posedge clk); #1;                      // now GET_HI
      Start = 1'b0; In_Valid = 1'b1; In_Data = 16'hCAFE;
      @(posedge clk); #1;                      // upper captured, now GET_LO
      In_Valid = 1'b0; In_Data = 16'h1111;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (OP_Code[31:16] !== 16'hCAFE || Write_Enable !== 1'b0) begin failures++; $display("FAIL stall_hold got=%h we=%b exp=cafe we=0", OP_Code[31:16], Write_Enable); end
      end
      In_Valid = 1'b1; In_Data = 16'hBABE;
      @(posedge clk); #1;                      // now WRITE
      In_Valid = 1'b0;
      checks++; if (Write_Enable !== 1'b1 || OP_Code !== 32'hCAFEBABE || Write_Address !== 32'h40) begin failures++; $display("FAIL stall_write got=%h@%h we=%b exp=cafebabe@00000040 we=1", OP_Code, Write_Address, Write_Enable); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (wr_addr_q.size() !== 1 || done_cnt !== 1) begin failures++; $display("FAIL stall_counts got writes=%0d done=%0d exp 1/1", wr_addr_q.size(), done_cnt); end
   endtask

   task automatic test_reset_midload();
      int unsigned idx;
      logic        hs;
      clear_mon();
      stream[0] = 16'hA1A1; stream[1] = 16'hA2A2; stream[2] = 16'hA3A3; stream[3] = 16'hA4A4;
      idx = 0;
      Start = 1'b1; Start_Address = 32'h500; Word_Count = 20'd3; In_Valid = 1'b1; In_Data = stream[0];
      // Edges 1..5: GET_HI, GET_LO, WRITE, GET_HI, GET_LO.
      for (int c = 0; c < 5; c++) begin
         hs = In_Valid && In_Ready;
         @(posedge clk); #1;
         Start = 1'b0;
         if (hs) idx++;
         In_Data = stream[idx % 8];
      end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (OP_Code !== 32'h0 || Write_Address !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h@%h exp=0@0", OP_Code, Write_Address); end
      checks++; if ({Write_Enable, In_Ready, Busy, Done} !== 4'b0000) begin failures++; $display("FAIL midrst_flags got=%b exp=0000", {Write_Enable, In_Ready, Busy, Done}); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      In_Valid = 1'b0;
      checks++; if (wr_addr_q.size() !== 1 || wr_addr(0) !== 32'h500 || wr_data(0) !== 32'hA1A1A2A2) begin failures++; $display("FAIL midrst_writes got n=%0d %h@%h exp n=1 a1a1a2a2@00000500", wr_addr_q.size(), wr_data(0), wr_addr(0)); end
      checks++; if (done_cnt !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt); end
   endtask

   task automatic test_start_ignored();
      int unsigned dc;
      clear_mon();
      stream[0] = 16'h1111; stream[1] = 16'h2222; stream[2] = 16'h3333;
      stream[3] = 16'h4444; stream[4] = 16'h5555; stream[5] = 16'h6666;
      // Odd start address: bit 0 is dropped, so writes begin at 0x300.
      run_load(32'h301, 20'd3, 2, 5, dc);
      checks++; if (dc !== 10) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=10", dc); end
      checks++; if (wr_addr_q.size() !== 3) begin failures++; $display("FAIL restart_nwrites got=%0d exp=3", wr_addr_q.size()); end
      checks++; if (wr_addr(0) !== 32'h300 || wr_addr(1) !== 32'h302 || wr_addr(2) !== 32'h304) begin failures++; $display("FAIL restart_addrs got=%h,%h,%h exp=300,302,304", wr_addr(0), wr_addr(1), wr_addr(2)); end
      checks++; if (wr_data(2) !== 32'h55556666) begin failures++; $display("FAIL restart_last_data got=%h exp=55556666", wr_data(2)); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done_cnt got=%0d exp=1", done_cnt); end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic();
      test_wrap();
      test_zero_count();
      test_valid_stall();
      test_reset_midload();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_inst_loader
